// File: rtl/store_write_buffer_if.sv
// Store/load/cache-write bundle for store_write_buffer. The slave modport is the
// buffer's view. The master modport is the view of the MEM stage and cache side.
interface store_write_buffer_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [31:0]   st_addr;
    logic [31:0]   st_wdata;
    logic [3:0]    st_wmask;
    logic          st_ready;
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic          ld_stall;
    logic          mem_write;
    logic [31:0]   mem_address;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_byte_enable;
    logic          mem_resp;
    logic          empty;
    logic [CW-1:0] count;

    modport slave (
        input  st_valid, st_addr, st_wdata, st_wmask, ld_valid, ld_addr, mem_resp,
        output st_ready, ld_stall, mem_write, mem_address, mem_wdata, mem_byte_enable,
               empty, count
    );

    modport master (
        output st_valid, st_addr, st_wdata, st_wmask, ld_valid, ld_addr, mem_resp,
        input  st_ready, ld_stall, mem_write, mem_address, mem_wdata, mem_byte_enable,
               empty, count
    );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-write buffer. Masked stores are queued in a circular FIFO and drained to the
// data cache one at a time. A load is stalled while any queued store covers its word.
module store_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    store_write_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [29:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [3:0]    r_mask [DEPTH];
    logic [31:0]   r_mem_address;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_be;
    logic          w_full;
    logic          w_enq;
    logic          w_pop;
    logic          w_launch;
    logic          w_hit;
    logic [PW-1:0] w_off;
    logic          w_unused;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_enq    = bus.st_valid && !w_full && (bus.st_wmask != 4'b0000);
    assign w_pop    = (r_state == S_WRITE) && bus.mem_resp;
    assign w_launch = (r_state == S_IDLE) && (w_state_nxt == S_WRITE);

    // Next-state logic for the drain FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_count != {CW{1'b0}}) || w_enq) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                if (bus.mem_resp) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WRITE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Drain FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage, pointers and occupancy counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= 30'd0;
                r_data[i] <= 32'd0;
                r_mask[i] <= 4'd0;
            end
        end else begin
            if (w_enq) begin
                r_addr[r_tail] <= bus.st_addr[31:2];
                r_data[r_tail] <= bus.st_wdata;
                r_mask[r_tail] <= bus.st_wmask;
                r_tail         <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Capture the cache request on entry to WRITE. With an empty FIFO the head
    // is being written at this same edge, so the request is taken from the store inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_address <= 32'd0;
            r_mem_wdata   <= 32'd0;
            r_mem_be      <= 4'd0;
        end else if (w_launch) begin
            if (r_count != {CW{1'b0}}) begin
                r_mem_address <= {r_addr[r_head], 2'b00};
                r_mem_wdata   <= r_data[r_head];
                r_mem_be      <= r_mask[r_head];
            end else begin
                r_mem_address <= {bus.st_addr[31:2], 2'b00};
                r_mem_wdata   <= bus.st_wdata;
                r_mem_be      <= bus.st_wmask;
            end
        end else begin
            r_mem_address <= r_mem_address;
            r_mem_wdata   <= r_mem_wdata;
            r_mem_be      <= r_mem_be;
        end
    end

    // Word-address match against every occupied slot, including the in-flight head
    always_comb begin
        w_hit = 1'b0;
        w_off = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_head;
            if (({1'b0, w_off} < r_count) && (r_addr[i] == bus.ld_addr[31:2])) begin
                w_hit = 1'b1;
            end else begin
                w_hit = w_hit;
            end
        end
    end

    assign bus.ld_stall        = bus.ld_valid && w_hit;
    assign bus.st_ready        = !w_full;
    assign bus.empty           = (r_count == {CW{1'b0}});
    assign bus.count           = r_count;
    assign bus.mem_write       = (r_state == S_WRITE);
    assign bus.mem_address     = r_mem_address;
    assign bus.mem_wdata       = r_mem_wdata;
    assign bus.mem_byte_enable = r_mem_be;

    assign w_unused = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};
endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed vector table, hand-written
// corner sequences, then random traffic scored against a queue model.
module tb_store_write_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;

    store_write_buffer_if #(.DEPTH(DEPTH)) bus ();
    store_write_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        st_valid;
        logic [31:0] st_addr;
        logic [31:0] st_wdata;
        logic [3:0]  st_wmask;
        logic        mem_resp;
        logic        ld_valid;
        logic [31:0] ld_addr;
        logic        e_mw;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [2:0]  e_count;
        logic        e_stall;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } ent_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.st_valid = 1'b0;
        bus.st_addr  = 32'd0;
        bus.st_wdata = 32'd0;
        bus.st_wmask = 4'd0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'd0;
        bus.mem_resp = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_wdata = d;
        bus.st_wmask = m;
    endtask

    function automatic vec_t mk(input logic stv, input logic [31:0] sta, input logic [31:0] std,
                                input logic [3:0] stm, input logic resp, input logic ldv,
                                input logic [31:0] lda, input logic emw, input logic [31:0] eaddr,
                                input logic [3:0] ebe, input logic [31:0] ewd,
                                input logic [2:0] ecnt, input logic estall);
        vec_t v;
        v.st_valid = stv;  v.st_addr = sta;  v.st_wdata = std;  v.st_wmask = stm;
        v.mem_resp = resp; v.ld_valid = ldv; v.ld_addr = lda;
        v.e_mw = emw; v.e_addr = eaddr; v.e_be = ebe; v.e_wdata = ewd;
        v.e_count = ecnt; v.e_stall = estall;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vt[$];
        ent_t        q[$];
        ent_t        e;
        logic [31:0] seen[$];
        logic        st_v;
        logic        resp;
        logic        exp_stall;
        logic        acc;
        int          lat;
        int          accepted;
        int          written;

        // Single store, responded after 3 cycles
        vt.push_back(mk(1'b1, 32'h1006, 32'hABCDABCD, 4'b1100, 1'b0, 1'b0, 32'h0,
                        1'b1, 32'h1004, 4'b1100, 32'hABCDABCD, 3'd1, 1'b0));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                        1'b1, 32'h1004, 4'b1100, 32'hABCDABCD, 3'd1, 1'b0));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                        1'b1, 32'h1004, 4'b1100, 32'hABCDABCD, 3'd1, 1'b0));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                        1'b0, 32'h0, 4'h0, 32'h0, 3'd0, 1'b0));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                        1'b0, 32'h0, 4'h0, 32'h0, 3'd0, 1'b0));
        // Enqueue and pop in the same cycle with two entries queued
        vt.push_back(mk(1'b1, 32'h3000, 32'h11111111, 4'hF, 1'b0, 1'b0, 32'h0,
                        1'b1, 32'h3000, 4'hF, 32'h11111111, 3'd1, 1'b0));
        vt.push_back(mk(1'b1, 32'h3010, 32'h22222222, 4'h3, 1'b0, 1'b0, 32'h0,
                        1'b1, 32'h3000, 4'hF, 32'h11111111, 3'd2, 1'b0));
        vt.push_back(mk(1'b1, 32'h3020, 32'h33333333, 4'hC, 1'b1, 1'b0, 32'h0,
                        1'b0, 32'h0, 4'h0, 32'h0, 3'd2, 1'b0));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                        1'b1, 32'h3010, 4'h3, 32'h22222222, 3'd2, 1'b0));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                        1'b0, 32'h0, 4'h0, 32'h0, 3'd1, 1'b0));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                        1'b1, 32'h3020, 4'hC, 32'h33333333, 3'd1, 1'b0));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                        1'b0, 32'h0, 4'h0, 32'h0, 3'd0, 1'b0));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                        1'b0, 32'h0, 4'h0, 32'h0, 3'd0, 1'b0));
        // Zero-mask store, then spurious response in IDLE
        vt.push_back(mk(1'b1, 32'h4000, 32'hDEADBEEF, 4'h0, 1'b0, 1'b0, 32'h0,
                        1'b0, 32'h0, 4'h0, 32'h0, 3'd0, 1'b0));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                        1'b0, 32'h0, 4'h0, 32'h0, 3'd0, 1'b0));
        // Load conflict against a pending word
        vt.push_back(mk(1'b1, 32'h2000, 32'h5A5A5A5A, 4'hF, 1'b0, 1'b0, 32'h0,
                        1'b1, 32'h2000, 4'hF, 32'h5A5A5A5A, 3'd1, 1'b0));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h2004,
                        1'b1, 32'h2000, 4'hF, 32'h5A5A5A5A, 3'd1, 1'b0));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h2003,
                        1'b1, 32'h2000, 4'hF, 32'h5A5A5A5A, 3'd1, 1'b1));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h2003,
                        1'b0, 32'h0, 4'h0, 32'h0, 3'd0, 1'b0));
        vt.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                        1'b0, 32'h0, 4'h0, 32'h0, 3'd0, 1'b0));

        // Reset state
        idle_inputs();
        rst_n = 1'b0;
        bus.ld_valid = 1'b1;
        #1;
        chk("rst_mem_write", bus.mem_write, 1'b0);
        chk("rst_mem_address", bus.mem_address, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_be", bus.mem_byte_enable, 4'h0);
        chk("rst_count", bus.count, 3'd0);
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_st_ready", bus.st_ready, 1'b1);
        chk("rst_ld_stall", bus.ld_stall, 1'b0);
        bus.ld_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Directed vector table
        foreach (vt[i]) begin
            bus.st_valid = vt[i].st_valid;
            bus.st_addr  = vt[i].st_addr;
            bus.st_wdata = vt[i].st_wdata;
            bus.st_wmask = vt[i].st_wmask;
            bus.mem_resp = vt[i].mem_resp;
            bus.ld_valid = vt[i].ld_valid;
            bus.ld_addr  = vt[i].ld_addr;
            tick();
            chk($sformatf("vec%0d_mem_write", i), bus.mem_write, vt[i].e_mw);
            chk($sformatf("vec%0d_count", i), bus.count, vt[i].e_count);
            chk($sformatf("vec%0d_empty", i), bus.empty, vt[i].e_count == 3'd0);
            chk($sformatf("vec%0d_st_ready", i), bus.st_ready, vt[i].e_count != 3'd4);
            chk($sformatf("vec%0d_ld_stall", i), bus.ld_stall, vt[i].e_stall);
            if (vt[i].e_mw) begin
                chk($sformatf("vec%0d_mem_address", i), bus.mem_address, vt[i].e_addr);
                chk($sformatf("vec%0d_mem_be", i), bus.mem_byte_enable, vt[i].e_be);
                chk($sformatf("vec%0d_mem_wdata", i), bus.mem_wdata, vt[i].e_wdata);
            end
        end
        idle_inputs();

        // Fill to DEPTH, drop a fifth store, drain in order
        for (int i = 0; i < 4; i++) begin
            store(32'h5000 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
            tick();
        end
        chk("full_count", bus.count, 3'd4);
        chk("full_st_ready", bus.st_ready, 1'b0);
        store(32'h5100, 32'hBADBAD00, 4'hF);
        tick();
        chk("full_drop_count", bus.count, 3'd4);
        idle_inputs();
        for (int c = 0; c < 40; c++) begin
            bus.mem_resp = bus.mem_write;
            if (bus.mem_write) seen.push_back(bus.mem_address);
            tick();
        end
        bus.mem_resp = 1'b0;
        chk("full_write_total", seen.size(), 4);
        foreach (seen[i]) chk($sformatf("full_order%0d", i), seen[i], 32'h5000 + 32'(4 * i));
        chk("full_drained_empty", bus.empty, 1'b1);

        // Reset while a write is in flight with three entries queued
        for (int i = 0; i < 3; i++) begin
            store(32'h6000 + 32'(4 * i), 32'h66660000 + 32'(i), 4'hF);
            tick();
        end
        idle_inputs();
        chk("rmid_pre_mem_write", bus.mem_write, 1'b1);
        chk("rmid_pre_count", bus.count, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_mem_write", bus.mem_write, 1'b0);
        chk("rmid_count", bus.count, 3'd0);
        chk("rmid_mem_address", bus.mem_address, 32'h0);
        chk("rmid_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rmid_mem_be", bus.mem_byte_enable, 4'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("rmid_post%0d_mem_write", c), bus.mem_write, 1'b0);
        end
        chk("rmid_post_empty", bus.empty, 1'b1);

        // Random traffic against a queue model
        lat = -1;
        accepted = 0;
        written = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd_count", bus.count, 32'(q.size()));
            chk("rnd_st_ready", bus.st_ready, q.size() < DEPTH);
            resp = 1'b0;
            if (bus.mem_write) begin
                if (lat < 0) lat = $urandom_range(0, 4);
                if (lat == 0) begin
                    resp = 1'b1;
                    lat = -1;
                end else begin
                    lat--;
                end
            end
            st_v = (cyc < 340) && ($urandom_range(0, 2) == 0);
            bus.st_valid = st_v;
            bus.st_addr  = 32'h2000 + 32'($urandom_range(0, 15));
            bus.st_wdata = $urandom;
            bus.st_wmask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            bus.ld_valid = !st_v && ($urandom_range(0, 1) == 1);
            bus.ld_addr  = 32'h2000 + 32'($urandom_range(0, 15));
            bus.mem_resp = resp;
            #1;
            exp_stall = 1'b0;
            foreach (q[k]) if (q[k].addr[31:2] == bus.ld_addr[31:2]) exp_stall = 1'b1;
            chk("rnd_ld_stall", bus.ld_stall, bus.ld_valid && exp_stall);
            acc = st_v && (q.size() < DEPTH) && (bus.st_wmask != 4'h0);
            if (resp) begin
                if (q.size() == 0) begin
                    chk("rnd_write_with_empty_model", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    chk("rnd_wr_addr", bus.mem_address, {e.addr[31:2], 2'b00});
                    chk("rnd_wr_data", bus.mem_wdata, e.data);
                    chk("rnd_wr_be", bus.mem_byte_enable, e.mask);
                    written++;
                end
            end
            if (acc) begin
                e.addr = bus.st_addr;
                e.data = bus.st_wdata;
                e.mask = bus.st_wmask;
                q.push_back(e);
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        chk("rnd_drain_model_empty", 32'(q.size()), 32'd0);
        chk("rnd_drain_dut_empty", bus.empty, 1'b1);
        chk("rnd_written_total", written, accepted);
        chk("rnd_enough_stores", accepted >= 10, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Posted-write buffer between the MEM stage and the data-cache write port. It accepts stores whose data and byte enables have already been lane-replicated and masked by the store-mask logic, and queues them in a small FIFO. It drains them to the cache one at a time with a `mem_write`/`mem_resp` handshake, and stalls any load whose word address matches a pending store.

## Interface
Parameters:
- `DEPTH`, 4: number of FIFO entries; power of two, at least 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `st_valid` in 1: MEM stage presents a store this cycle.
- `st_addr` in 32: byte address of the store.
- `st_wdata` in 32: lane-replicated store data.
- `st_wmask` in 4: byte enables.
- `st_ready` out 1: buffer can accept a store; equals `count != DEPTH`.
- `ld_valid` in 1: MEM stage presents a load this cycle.
- `ld_addr` in 32: byte address of the load.
- `ld_stall` out 1: combinational; load must hold because of a word-address conflict.
- `mem_write` out 1: registered write request to the data cache.
- `mem_address` out 32: `{head.addr[31:2], 2'b00}`.
- `mem_wdata` out 32: head entry data.
- `mem_byte_enable` out 4: head entry mask.
- `mem_resp` in 1: one-cycle write acknowledge from the cache.
- `empty` out 1: `count == 0`.
- `count` out `$clog2(DEPTH)+1`: number of occupied entries.

## Operation
- Storage is a circular FIFO with head and tail pointers of `$clog2(DEPTH)` bits that wrap modulo `DEPTH`, plus a separate counter. Each entry holds `addr[31:2]`, `wdata` and `wmask`.
- **Enqueue** occurs when `st_valid && st_ready && st_wmask != 0`. The entry is written at the tail and the tail advances.
- A store with `st_wmask == 0` is acknowledged (no stall) but is not enqueued.
- `st_valid` while full is ignored. The upstream stage must stall on `!st_ready`. `st_ready` does not look ahead at `mem_resp`.
- **Pop** occurs when `mem_resp` is seen in state WRITE. The head advances.
- Enqueue and pop in the same cycle leave `count` unchanged. Both pointers move.
- The FSM has two states, IDLE and WRITE.
  - IDLE to WRITE on a clock edge when `count != 0` or an enqueue is occurring.
  - WRITE to IDLE on the edge where `mem_resp` is high.
  - `mem_write = (state == WRITE)`.
  - While in WRITE, `mem_address`, `mem_wdata` and `mem_byte_enable` hold the head entry stably until `mem_resp`.
- `mem_resp` seen while in IDLE is ignored. It causes no pop and no error.
- **Load conflict:** `ld_stall = ld_valid && (any occupied entry, including the in-flight head, has addr[31:2] == ld_addr[31:2])`.
  - There is no partial or full forwarding.
  - `ld_stall` drops in the cycle after the last matching entry is popped.
- A store and a load are never presented in the same cycle (in-order, single MEM stage). Behaviour is unspecified if both are asserted.

## Timing
- **Reset** (asynchronous, immediate):
  - state = IDLE, `head = tail = 0`, `count = 0`, all entries cleared.
  - `mem_write = 0`, `mem_address = 0`, `mem_wdata = 0`, `mem_byte_enable = 0`.
  - `st_ready = 1`, `empty = 1`, `ld_stall = 0`.
- **Reset mid-transaction:** `mem_write` drops without waiting for `mem_resp`, and all pending stores are discarded.
- **Enqueue to request:** a store enqueued into an empty buffer at edge k gives `mem_write = 1` in the cycle after edge k (latency 1).
- **Response to next request:** after the `mem_resp` edge, `mem_write` is low for exactly one cycle. WRITE is re-entered at the next edge if `count != 0`.
- **Throughput:** one store per 2 cycles plus the cache latency.
- **Full / empty flags:** `count`, `empty` and `st_ready` are registered-state derived and update the cycle after enqueue or pop.
- **Pointer wrap:** after `DEPTH` enqueues, tail returns to 0, and the FIFO order across the wrap is preserved.

## Test plan
- Reset, then one store (`st_addr = 0x1006`, `st_wdata = 0xABCDABCD`, `st_wmask = 4'b1100`) → next cycle `mem_write = 1`, `mem_address = 0x1004`, `mem_byte_enable = 4'b1100`. With `mem_resp` after 3 cycles → `count` returns to 0 and `empty = 1`.
- 4 back-to-back stores with `mem_resp` held low → `count = 4`, `st_ready = 0`. A 5th `st_valid` is dropped. After 4 responses, addresses are seen in enqueue order and the 5th store never appears.
- Enqueue and `mem_resp` in the same cycle with `count = 2` → `count` stays 2, and the next `mem_address` is the second-oldest entry.
- Pending store to `0x2000`, then a load to `0x2003` → `ld_stall = 1` until the cycle after that entry's `mem_resp`. A load to `0x2004` → `ld_stall = 0`.
- Store with `st_wmask = 0` → no `count` change and no `mem_write`. A spurious `mem_resp` in IDLE → no pop.
- Assert `rst_n = 0` while `mem_write = 1` and `count = 3` → `mem_write`, `count` and all `mem_*` outputs are 0 immediately. After release, no write is issued.
- 10 stores with `DEPTH = 4`, each drained with random response latency 1–5 cycles → all 10 are written in order with data intact across pointer wrap.
